// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA pixel-plot port between NUM_REQ requesters
// using round-robin valid/ready arbitration, with a built-in full-screen clear sweep.
module vga_plot_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned X_MAX   = 159,
    parameter int unsigned Y_MAX   = 119
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_x,
    input  logic [7*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    input  logic                   clear_start,
    input  logic [2:0]             clear_colour,
    output logic                   clear_busy,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   vga_resetn
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  X_LAST = 8'(X_MAX);
    localparam logic [6:0]  Y_LAST = 7'(Y_MAX);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic [2:0]         colour_q, colour_d;
    logic               plot_q, plot_d;
    logic               busy_q, busy_d;
    logic               vga_resetn_q, vga_resetn_d;
    logic [2:0]         clr_colour_q, clr_colour_d;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [7:0]         grant_x;
    logic [6:0]         grant_y;
    logic [2:0]         grant_colour;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_q) + 32'd1 + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Select the granted requester's pixel fields
    always_comb begin
        grant_x      = '0;
        grant_y      = '0;
        grant_colour = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                grant_x      = req_x[8*i +: 8];
                grant_y      = req_y[7*i +: 7];
                grant_colour = req_colour[3*i +: 3];
            end
        end
    end

    // Next-state, handshake and pixel output selection
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        vga_resetn_d = 1'b1;
        clr_colour_d = clr_colour_q;
        req_ready    = '0;

        case (state_q)
            ARB: begin
                if (clear_start) begin
                    // First clear pixel is loaded now so it appears the next cycle
                    clr_colour_d = clear_colour;
                    x_d          = '0;
                    y_d          = '0;
                    colour_d     = clear_colour;
                    plot_d       = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = CLEAR;
                end else if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    rr_d                 = grant_idx;
                    // Off-screen pixels are consumed but never plotted
                    if (grant_x <= X_LAST && grant_y <= Y_LAST) begin
                        x_d      = grant_x;
                        y_d      = grant_y;
                        colour_d = grant_colour;
                        plot_d   = 1'b1;
                    end
                end
            end
            CLEAR: begin
                // x_q/y_q hold the pixel currently presented; step y inner, x outer
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    state_d = ARB;
                end else begin
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    colour_d = clr_colour_q;
                    if (y_q == Y_LAST) begin
                        y_d = '0;
                        x_d = x_q + 8'd1;
                    end else begin
                        y_d = y_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ARB;
            rr_q         <= IDX_W'(NUM_REQ - 1);
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            vga_resetn_q <= 1'b0;
            clr_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            vga_resetn_q <= vga_resetn_d;
            clr_colour_q <= clr_colour_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign clear_busy = busy_q;
    assign vga_resetn = vga_resetn_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: expected pixels are queued as stimulus is driven.
module tb_vga_plot_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned XM = 159;
    localparam int unsigned YM = 119;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [15:0]   req_x;
    logic [13:0]   req_y;
    logic [5:0]    req_colour;
    logic          clear_start;
    logic [2:0]    clear_colour;
    logic          clear_busy;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    colour;
    logic          plot;
    logic          vga_resetn;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       plot;
        logic       busy;
        logic       rn;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    exp_t       got;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    int         n_chk;
    int         n_fail;

    always #5 clk = ~clk;

    vga_plot_arbiter #(.NUM_REQ(NR), .X_MAX(XM), .Y_MAX(YM)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_colour  (req_colour),
        .clear_start (clear_start),
        .clear_colour(clear_colour),
        .clear_busy  (clear_busy),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .vga_resetn  (vga_resetn)
    );

    // Expected output builders (outputs hold x/y/colour whenever nothing is plotted)
    function automatic void push_plot(input logic [7:0] px, input logic [6:0] py,
                                      input logic [2:0] pc, input logic busy);
        exp_t t;
        hx = px; hy = py; hc = pc;
        t = '{x: px, y: py, c: pc, plot: 1'b1, busy: busy, rn: 1'b1};
        sb.push_back(t);
    endfunction

    function automatic void push_idle();
        exp_t t;
        t = '{x: hx, y: hy, c: hc, plot: 1'b0, busy: 1'b0, rn: 1'b1};
        sb.push_back(t);
    endfunction

    function automatic void push_reset();
        exp_t t;
        hx = '0; hy = '0; hc = '0;
        t = '{x: 8'd0, y: 7'd0, c: 3'd0, plot: 1'b0, busy: 1'b0, rn: 1'b0};
        sb.push_back(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] c0,
                           input logic [7:0] x1, input logic [6:0] y1, input logic [2:0] c1);
        req_x      = {x1, x0};
        req_y      = {y1, y0};
        req_colour = {c1, c0};
    endtask

    task automatic test_reset();
        logic [1:0] er;
        for (int t = 0; t < 3; t++) begin
            reset     = (t < 2);
            req_valid = (t < 2) ? 2'b11 : 2'b00;
            er        = 2'b00;
            #3;
            n_chk++;
            if (req_ready !== er) begin
                n_fail++;
                $display("FAIL reset_ready t=%0d: got %b exp %b", t, req_ready, er);
            end
            if (t < 2) push_reset(); else push_idle();
            tick();
            got = {x, y, colour, plot, clear_busy, vga_resetn};
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL reset_out t=%0d: scoreboard empty", t);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL reset_out t=%0d: got %h exp %h", t, got, e);
                end
            end
        end
    endtask

    task automatic test_alternate();
        logic [1:0] er;
        set_req(8'd10, 7'd20, 3'd3, 8'd30, 7'd40, 3'd5);
        for (int t = 0; t < 8; t++) begin
            req_valid = 2'b11;
            er        = (t % 2 == 0) ? 2'b01 : 2'b10;
            #3;
            n_chk++;
            if (req_ready !== er) begin
                n_fail++;
                $display("FAIL alt_ready t=%0d: got %b exp %b", t, req_ready, er);
            end
            if (er == 2'b01) push_plot(8'd10, 7'd20, 3'd3, 1'b0);
            else             push_plot(8'd30, 7'd40, 3'd5, 1'b0);
            tick();
            got = {x, y, colour, plot, clear_busy, vga_resetn};
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL alt_out t=%0d: scoreboard empty", t);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL alt_out t=%0d: got %h exp %h", t, got, e);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [1:0] er;
        logic [1:0] vseq [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
        logic [1:0] gseq [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        for (int t = 0; t < 5; t++) begin
            req_valid = vseq[t];
            er        = gseq[t];
            #3;
            n_chk++;
            if (req_ready !== er) begin
                n_fail++;
                $display("FAIL prio_ready t=%0d: got %b exp %b", t, req_ready, er);
            end
            if (er == 2'b01) push_plot(8'd10, 7'd20, 3'd3, 1'b0);
            else             push_plot(8'd30, 7'd40, 3'd5, 1'b0);
            tick();
            got = {x, y, colour, plot, clear_busy, vga_resetn};
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL prio_out t=%0d: scoreboard empty", t);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL prio_out t=%0d: got %h exp %h", t, got, e);
                end
            end
        end
    endtask

    task automatic test_clip();
        logic [1:0] er;
        for (int t = 0; t < 6; t++) begin
            case (t)
                0: begin set_req(8'd160, 7'd5, 3'd1, 8'd30, 7'd40, 3'd5); req_valid = 2'b01; er = 2'b01; end
                1: begin req_valid = 2'b11; er = 2'b10; end
                2: begin req_valid = 2'b11; er = 2'b01; end
                3: begin set_req(8'd5, 7'd120, 3'd2, 8'd30, 7'd40, 3'd5); req_valid = 2'b01; er = 2'b01; end
                4: begin set_req(8'd159, 7'd119, 3'd7, 8'd30, 7'd40, 3'd5); req_valid = 2'b01; er = 2'b01; end
                default: begin req_valid = 2'b00; er = 2'b00; end
            endcase
            #3;
            n_chk++;
            if (req_ready !== er) begin
                n_fail++;
                $display("FAIL clip_ready t=%0d: got %b exp %b", t, req_ready, er);
            end
            case (t)
                1:       push_plot(8'd30, 7'd40, 3'd5, 1'b0);
                4:       push_plot(8'd159, 7'd119, 3'd7, 1'b0);
                default: push_idle();
            endcase
            tick();
            got = {x, y, colour, plot, clear_busy, vga_resetn};
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL clip_out t=%0d: scoreboard empty", t);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL clip_out t=%0d: got %h exp %h", t, got, e);
                end
            end
        end
    endtask

    task automatic test_clear();
        logic [1:0] er;
        int         npix;
        npix = (XM + 1) * (YM + 1);
        set_req(8'd10, 7'd20, 3'd3, 8'd30, 7'd40, 3'd5);
        for (int t = 0; t <= npix + 1; t++) begin
            req_valid    = 2'b01;
            clear_start  = (t == 0) || (t == 5000);
            clear_colour = (t == 0) ? 3'd6 : 3'd2;
            er           = (t == npix + 1) ? 2'b01 : 2'b00;
            #3;
            n_chk++;
            if (req_ready !== er) begin
                n_fail++;
                $display("FAIL clear_ready t=%0d: got %b exp %b", t, req_ready, er);
            end
            if (t < npix)       push_plot(8'(t / (YM + 1)), 7'(t % (YM + 1)), 3'd6, 1'b1);
            else if (t == npix) push_idle();
            else                push_plot(8'd10, 7'd20, 3'd3, 1'b0);
            tick();
            got = {x, y, colour, plot, clear_busy, vga_resetn};
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL clear_out t=%0d: scoreboard empty", t);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL clear_out t=%0d: got %h exp %h", t, got, e);
                end
            end
        end
        clear_start = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        logic [1:0] er;
        for (int t = 0; t <= 503; t++) begin
            clear_start  = (t == 0);
            clear_colour = 3'd1;
            reset        = (t == 500);
            req_valid    = (t == 502) ? 2'b11 : ((t == 503) ? 2'b00 : 2'b01);
            er           = (t == 501) ? 2'b01 : ((t == 502) ? 2'b10 : 2'b00);
            #3;
            n_chk++;
            if (req_ready !== er) begin
                n_fail++;
                $display("FAIL abort_ready t=%0d: got %b exp %b", t, req_ready, er);
            end
            if (t < 500)       push_plot(8'(t / (YM + 1)), 7'(t % (YM + 1)), 3'd1, 1'b1);
            else if (t == 500) push_reset();
            else if (t == 501) push_plot(8'd10, 7'd20, 3'd3, 1'b0);
            else if (t == 502) push_plot(8'd30, 7'd40, 3'd5, 1'b0);
            else               push_idle();
            tick();
            got = {x, y, colour, plot, clear_busy, vga_resetn};
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL abort_out t=%0d: scoreboard empty", t);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL abort_out t=%0d: got %h exp %h", t, got, e);
                end
            end
        end
        clear_start = 1'b0;
        reset       = 1'b0;
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        hx           = '0;
        hy           = '0;
        hc           = '0;
        reset        = 1'b1;
        req_valid    = '0;
        req_x        = '0;
        req_y        = '0;
        req_colour   = '0;
        clear_start  = 1'b0;
        clear_colour = '0;
        test_reset();
        test_alternate();
        test_priority();
        test_clip();
        test_clear();
        test_reset_mid_clear();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d leftover entries exp 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single VGA pixel-plot port (x, y, colour, plot) between NUM_REQ independent pixel requesters. It also contains a built-in full-screen clear sequencer. Requests use a per-requester valid/ready handshake with round-robin arbitration, and at most one pixel is issued per clock. The block sits between drawing engines (sprites, counters, demo patterns) and the top-level VGA outputs of `main`.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (1–8)
- X_MAX, 159, largest legal x coordinate
- Y_MAX, 119, largest legal y coordinate

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- CLOCK_50  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a pixel to plot
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- req_x  in  8*NUM_REQ  x of requester i at bits [8i+7:8i]
- req_y  in  7*NUM_REQ  y of requester i at bits [7i+6:7i]
- req_colour  in  3*NUM_REQ  colour of requester i at bits [3i+2:3i]
- clear_start  in  1  single-cycle request to fill the screen with clear_colour
- clear_colour  in  3  fill colour, sampled when clear_start is accepted
- clear_busy  out  1  high while clear pixels are being issued
- x  out  8  registered pixel x
- y  out  7  registered pixel y
- colour  out  3  registered pixel colour
- plot  out  1  registered; pixel written when high
- vga_resetn  out  1  registered; 0 during reset, 1 otherwise

## Operation
- States:
  - ARB: arbitrating requests.
  - CLEAR: sweeping the screen.
- reset: state=ARB, rr pointer=NUM_REQ-1 (requester 0 wins first), x=0, y=0, colour=0, plot=0, clear_busy=0, vga_resetn=0, req_ready=0.
- ARB, clear_start=1:
  - Takes priority over all requests that cycle, so req_ready=0.
  - Latch clear_colour, go to CLEAR.
- ARB, clear_start=0:
  - Grant goes to the first i with req_valid[i]=1, scanning from (rr+1) mod NUM_REQ upward with wrap.
  - req_ready is the one-hot grant, or all zero if no request is valid.
  - req_ready depends combinationally on req_valid; requesters must not derive req_valid from req_ready.
- On transfer:
  - Register x/y/colour from the granted requester and set plot=1.
  - Set rr to the granted index.
- No transfer: plot=0; x/y/colour hold their previous values.
- Clipping: if the granted request has x>X_MAX or y>Y_MAX, it is still accepted (ready asserted) and rr updates, but plot=0 and x/y/colour hold.
- CLEAR sweep:
  - One pixel per cycle, y inner loop (0..Y_MAX) and x outer loop (0..X_MAX), colour = latched clear_colour, plot=1.
  - req_ready=0 throughout.
  - clear_start is ignored during CLEAR.
  - After pixel (X_MAX,Y_MAX) the state returns to ARB; rr is unchanged by the clear.
- clear_busy=1 exactly on the cycles in which a clear pixel is presented on the outputs.
- reset during CLEAR aborts the sweep: reset values apply on the next cycle, and no further clear pixels are issued.

## Timing
- Transfer in cycle N: x/y/colour/plot=1 visible in cycle N+1. Throughput is one pixel per cycle with back-to-back grants.
- clear_start accepted in cycle N:
  - Pixel (0,0) is visible in N+1 and pixel (X_MAX,Y_MAX) in N+(X_MAX+1)(Y_MAX+1) (N+19200 with defaults).
  - clear_busy is high over the same cycles.
  - req_ready may first reassert in cycle N+19201.
- vga_resetn: 0 in the cycle after any cycle with reset=1, then 1 from the cycle after the first cycle with reset=0.
- Counter widths: x counter 8 bits, y counter 7 bits. Compare against X_MAX/Y_MAX; never rely on natural overflow.

## Test plan
- Reset, then both requesters valid continuously with fixed coordinates (10,20,c=3) and (30,40,c=5):
  - req_ready alternates 01,10,01,… starting with requester 0.
  - The outputs alternate those pixels one cycle later with plot=1 every cycle.
- Only requester 1 valid for 3 cycles, then both valid:
  - Grants go 1,1,1, then 0 (rr=1 passes priority to 0), then 1.
- Out-of-range request (x=160, y=5):
  - req_ready=1 and the transfer completes.
  - plot=0 next cycle; x/y/colour retain their previous values.
- clear_start with colour 6 in cycle N while requester 0 is valid:
  - req_ready=0 in N.
  - Pixel (0,0,6) in N+1, (0,119) in N+120, (1,0) in N+121, (159,119) in N+19200.
  - clear_busy high for exactly 19200 cycles; requester 0 is granted in N+19201.
  - A second clear_start mid-sweep has no effect.
- Assert reset at clear pixel 500 for 1 cycle:
  - The next cycle shows plot=0, clear_busy=0, vga_resetn=0, state ARB.
  - The following cycle shows vga_resetn=1 and requests are granted again from requester 0.
